// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//
// Purpose:
//   Shares a single 4-bit full-add slice between two requesters. In IDLE a
//   round-robin arbiter picks one requester and latches its wide operands.
//   The slice is then stepped over NIBBLES cycles, least-significant nibble
//   first, with the carry held in a register between steps. The finished
//   sum, carry-out and owning requester ID are offered on a valid/ready
//   result port and held until the consumer takes them.
//
// Parameters:
//   NIBBLES     operand width in nibbles (1..16); W = 4*NIBBLES
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   req0_valid  requester 0 has operands
//   req0_ready  requester 0 operands accepted this cycle (with req0_valid)
//   req0_a/b    requester 0 operands, W bits
//   req1_valid  requester 1 has operands
//   req1_ready  requester 1 operands accepted this cycle (with req1_valid)
//   req1_a/b    requester 1 operands, W bits
//   res_valid   result available
//   res_ready   consumer takes the result
//   res_sum     a + b modulo 2^W
//   res_cout    carry out of bit W-1
//   res_id      requester that owns the result
//   busy        high in any state other than IDLE
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_sum,
  output logic                   res_cout,
  output logic                   res_id,
  output logic                   busy
);

  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           id_q, id_d;
  logic           valid_q, valid_d;
  logic           carry_q, carry_d;
  logic [3:0]     idx_q, idx_d;
  logic           last_grant_q, last_grant_d;

  logic           grant0;
  logic           grant1;
  logic [3:0]     nibA;
  logic [3:0]     nibB;
  logic [4:0]     addRes;

  // Round-robin arbitration: a lone requester always wins; on a tie the
  // requester that was not granted last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  // Ready and busy are forced low while reset is asserted so that the
  // requesters never see a handshake before the state register is known.
  assign req0_ready = rst_n && grant0;
  assign req1_ready = rst_n && grant1;
  assign busy       = rst_n && (state_q != IDLE);

  assign res_valid  = valid_q;
  assign res_sum    = sum_q;
  assign res_cout   = cout_q;
  assign res_id     = id_q;

  // Select the current operand nibbles with constant slices so the mux stays
  // in range for every legal NIBBLES, including 1.
  always_comb begin
    nibA = 4'd0;
    nibB = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == 4'(n)) begin
        nibA = a_q[4*n +: 4];
        nibB = b_q[4*n +: 4];
      end
    end
  end

  // The shared slice: one 4-bit add with carry-in from the carry register.
  assign addRes = {1'b0, nibA} + {1'b0, nibB} + {4'd0, carry_q};

  // Next-state and datapath updates. Defaults hold every register; each
  // state only overrides what it changes.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    id_d         = id_q;
    valid_d      = valid_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_d          = grant1 ? req1_a : req0_a;
          b_d          = grant1 ? req1_b : req0_b;
          id_d         = grant1;
          last_grant_d = grant1;
          carry_d      = 1'b0;
          idx_d        = 4'd0;
          state_d      = RUN;
        end
      end

      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == 4'(n)) begin
            sum_d[4*n +: 4] = addRes[3:0];
          end
        end
        carry_d = addRes[4];
        idx_d   = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          cout_d  = addRes[4];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset aborts any operation in flight and clears all
  // visible outputs; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      valid_q      <= 1'b0;
      carry_q      <= 1'b0;
      idx_q        <= 4'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
      valid_q      <= valid_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
//
// Purpose:
//   Directed bench for nibble_serial_add_ctrl. A NIBBLES=4 instance covers
//   arbitration, carry ripple, back-pressure and mid-operation reset; a
//   NIBBLES=1 instance covers the single-step case. Expected values are
//   hand-computed constants.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;

  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready;
  logic [15:0] res_sum;
  logic        res_cout, res_id, busy;

  logic        s0Valid, s0Ready;
  logic [3:0]  s0A, s0B;
  logic        s1Valid, s1Ready;
  logic [3:0]  s1A, s1B;
  logic        sResValid, sResReady;
  logic [3:0]  sResSum;
  logic        sResCout, sResId, sBusy;

  int cmpCount;
  int failCount;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dutSmall (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (s0Valid),
    .req0_ready (s0Ready),
    .req0_a     (s0A),
    .req0_b     (s0B),
    .req1_valid (s1Valid),
    .req1_ready (s1Ready),
    .req1_a     (s1A),
    .req1_b     (s1B),
    .res_valid  (sResValid),
    .res_ready  (sResReady),
    .res_sum    (sResSum),
    .res_cout   (sResCout),
    .res_id     (sResId),
    .busy       (sBusy)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until res_valid is seen high; -1 if it never arrives.
  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      step();
      cyc++;
    end
    if (!res_valid) cyc = -1;
  endtask

  // Outputs during and right after reset are all zero.
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    cmpCount++;
    if ({req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy} !== 22'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got r0=%b r1=%b v=%b sum=%h c=%b id=%b busy=%b, want all 0",
               req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy);
    end
    cmpCount++;
    if ({s0Ready, s1Ready, sResValid, sResSum, sResCout, sResId, sBusy} !== 10'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs_n1: got v=%b sum=%h busy=%b, want all 0",
               sResValid, sResSum, sBusy);
    end
    rst_n = 1'b1;
  endtask

  // 0xFFFF + 0x0001 from requester 0: carry ripples out of every nibble.
  task automatic test_carry_all();
    int cyc;
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    cmpCount++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL carry_all_ready: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    cmpCount++;
    if (busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL carry_all_busy: got %b, want 1", busy);
    end
    waitValid(cyc);
    cmpCount++;
    if (cyc !== 4) begin
      failCount++;
      $display("[TB] FAIL carry_all_latency: got %0d, want 4", cyc);
    end
    cmpCount++;
    if (res_sum !== 16'h0000 || res_cout !== 1'b1 || res_id !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL carry_all_result: got sum=%h c=%b id=%b, want sum=0000 c=1 id=0",
               res_sum, res_cout, res_id);
    end
    step();
    cmpCount++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL carry_all_return: got v=%b busy=%b, want v=0 busy=0", res_valid, busy);
    end
  endtask

  // 0x0F0F + 0x00F1 from requester 1: carry ripples 0->1->2 and stops.
  task automatic test_ripple();
    int cyc;
    req1_a = 16'h0F0F; req1_b = 16'h00F1; req1_valid = 1'b1;
    #1;
    cmpCount++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ripple_ready: got r0=%b r1=%b, want r0=0 r1=1", req0_ready, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    waitValid(cyc);
    cmpCount++;
    if (cyc !== 4 || res_sum !== 16'h1000 || res_cout !== 1'b0 || res_id !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ripple_result: got cyc=%0d sum=%h c=%b id=%b, want cyc=4 sum=1000 c=0 id=1",
               cyc, res_sum, res_cout, res_id);
    end
    step();
  endtask

  // Both requesters valid from reset: results alternate id0, id1, id0.
  task automatic test_round_robin();
    int          resCount;
    logic        expId;
    logic [15:0] expSum;
    logic        expCout;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_a = 16'h1234; req0_b = 16'h1111; req0_valid = 1'b1;
    req1_a = 16'h8000; req1_b = 16'h8000; req1_valid = 1'b1;
    res_ready = 1'b1;
    resCount = 0;
    for (int c = 0; c < 60 && resCount < 3; c++) begin
      step();
      cmpCount++;
      if ((req0_ready & req1_ready) !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL rr_both_ready: got r0=%b r1=%b at cycle %0d, want not both",
                 req0_ready, req1_ready, c);
      end
      if (res_valid === 1'b1) begin
        expId   = (resCount == 1);
        expSum  = expId ? 16'h0000 : 16'h2345;
        expCout = expId;
        cmpCount++;
        if (res_id !== expId || res_sum !== expSum || res_cout !== expCout) begin
          failCount++;
          $display("[TB] FAIL rr_result%0d: got id=%b sum=%h c=%b, want id=%b sum=%h c=%b",
                   resCount, res_id, res_sum, res_cout, expId, expSum, expCout);
        end
        resCount++;
        if (resCount == 3) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    cmpCount++;
    if (resCount !== 3) begin
      failCount++;
      $display("[TB] FAIL rr_count: got %0d results, want 3", resCount);
    end
    step();
  endtask

  // Consumer stalls for 5 cycles: result must hold and nothing is accepted.
  task automatic test_backpressure();
    int cyc;
    res_ready = 1'b0;
    req0_a = 16'h1234; req0_b = 16'h4321; req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    waitValid(cyc);
    cmpCount++;
    if (cyc !== 4) begin
      failCount++;
      $display("[TB] FAIL bp_latency: got %0d, want 4", cyc);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      cmpCount++;
      if (res_valid !== 1'b1 || res_sum !== 16'h5555 || res_cout !== 1'b0 || res_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL bp_hold%0d: got v=%b sum=%h c=%b id=%b r0=%b r1=%b busy=%b, want v=1 sum=5555 c=0 id=0 r0=0 r1=0 busy=1",
                 k, res_valid, res_sum, res_cout, res_id, req0_ready, req1_ready, busy);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    step();
    cmpCount++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bp_release: got v=%b busy=%b, want v=0 busy=0", res_valid, busy);
    end
  endtask

  // Reset after 2 RUN edges aborts the add; the next add has no stale carry,
  // and the first tie after reset goes to requester 0.
  task automatic test_mid_reset();
    int cyc;
    req0_a = 16'hFFFF; req0_b = 16'hFFFF; req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    cmpCount++;
    if ({req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy} !== 22'd0) begin
      failCount++;
      $display("[TB] FAIL midrst_outputs: got r0=%b r1=%b v=%b sum=%h c=%b id=%b busy=%b, want all 0",
               req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy);
    end
    rst_n = 1'b1;
    req0_a = 16'h0003; req0_b = 16'h0004; req0_valid = 1'b1;
    req1_a = 16'h1111; req1_b = 16'h2222; req1_valid = 1'b1;
    #1;
    cmpCount++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrst_tie: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitValid(cyc);
    cmpCount++;
    if (cyc !== 4 || res_sum !== 16'h0007 || res_cout !== 1'b0 || res_id !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrst_result: got cyc=%0d sum=%h c=%b id=%b, want cyc=4 sum=0007 c=0 id=0",
               cyc, res_sum, res_cout, res_id);
    end
    step();
  endtask

  // NIBBLES=1: 0x9 + 0x8 completes after a single RUN edge.
  task automatic test_nibbles1();
    int cyc;
    s0A = 4'h9; s0B = 4'h8; s0Valid = 1'b1;
    sResReady = 1'b1;
    #1;
    cmpCount++;
    if (s0Ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL n1_ready: got %b, want 1", s0Ready);
    end
    step();
    s0Valid = 1'b0;
    cyc = 0;
    while (!sResValid && cyc < 10) begin
      step();
      cyc++;
    end
    if (!sResValid) cyc = -1;
    cmpCount++;
    if (cyc !== 1 || sResSum !== 4'h1 || sResCout !== 1'b1 || sResId !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL n1_result: got cyc=%0d sum=%h c=%b id=%b, want cyc=1 sum=1 c=1 id=0",
               cyc, sResSum, sResCout, sResId);
    end
    step();
    cmpCount++;
    if (sResValid !== 1'b0 || sBusy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL n1_return: got v=%b busy=%b, want v=0 busy=0", sResValid, sBusy);
    end
  endtask

  // Test sequence.
  initial begin
    cmpCount   = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready  = 1'b0;
    s0Valid    = 1'b0; s0A = '0; s0B = '0;
    s1Valid    = 1'b0; s1A = '0; s1B = '0;
    sResReady  = 1'b0;

    test_reset();
    test_carry_all();
    test_ripple();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_nibbles1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
